// File: rtl/regfile_write_arbiter.sv
// Arbitrates the register file's single write port between ALU (req0) and multi-cycle (req1)
// writeback, and keeps a pending-write scoreboard. Define RR_ARB_EN for round-robin arbitration.
module regfile_write_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              pend_set,
  input  logic [ADDR_W-1:0] pend_addr,
  output logic              rf_reg_write,
  output logic [ADDR_W-1:0] rf_add_write,
  output logic [DATA_W-1:0] rf_data_write,
  output logic [31:0]       busy_mask,
  output logic [3:0]        starve_cnt
);

  // Handshake: a requester holds valid/addr/data stable until valid & ready at a rising
  // edge; ready is combinational and only asserts for a valid requester that wins.

  logic              w_grant0;
  logic              w_grant1;
  logic              w_xfer;
  logic              w_contest;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_data;
  logic [31:0]       w_busy_nxt;

  logic              r_reg_write;
  logic [ADDR_W-1:0] r_add_write;
  logic [DATA_W-1:0] r_data_write;
  logic [31:0]       r_busy;
  logic [3:0]        r_starve;

  assign w_contest = req0_valid & req1_valid;

`ifdef RR_ARB_EN
  // r_last_gnt1 = 1 means req1 won the most recent transfer, so req0 has priority.
  logic r_last_gnt1;

  assign w_grant1 = req1_valid & (~req0_valid | ~r_last_gnt1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_gnt1 <= 1'b1;
    end else if (w_xfer) begin
      r_last_gnt1 <= w_grant1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_starve <= 4'd0;
    end else begin
      r_starve <= 4'd0;
    end
  end
`else
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  assign w_grant1 = req1_valid & (~req0_valid | (r_starve >= STARVE_LIM));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_starve <= 4'd0;
    end else if (w_grant1) begin
      r_starve <= 4'd0;
    end else if (w_contest && (r_starve != 4'd15)) begin
      r_starve <= r_starve + 4'd1;
    end
  end
`endif

  assign w_grant0   = req0_valid & ~w_grant1;
  assign w_xfer     = w_grant0 | w_grant1;
  assign w_win_addr = w_grant1 ? req1_addr : req0_addr;
  assign w_win_data = w_grant1 ? req1_data : req0_data;

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  // Register 0 writes are granted but never presented to the register file.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_reg_write  <= 1'b0;
      r_add_write  <= '0;
      r_data_write <= '0;
    end else begin
      r_reg_write <= w_xfer && (w_win_addr != '0);
      if (w_xfer) begin
        r_add_write  <= w_win_addr;
        r_data_write <= w_win_data;
      end
    end
  end

  // Set is applied after clear so a same-edge set of the same register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_reg_write) begin
      w_busy_nxt[r_add_write] = 1'b0;
    end
    if (pend_set && (pend_addr != '0)) begin
      w_busy_nxt[pend_addr] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy <= 32'd0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign rf_reg_write  = r_reg_write;
  assign rf_add_write  = r_add_write;
  assign rf_data_write = r_data_write;
  assign busy_mask     = r_busy;
  assign starve_cnt    = r_starve;

endmodule
